// File: rtl/writeback_queue.sv
// Writeback queue: merges ALU and LSU results into a FIFO that feeds
// the register-file write port, with hazard lookups on pending writes.
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       ALU_VALID,
  input  logic [4:0]                 ALU_RD,
  input  logic [31:0]                ALU_DATA,
  output logic                       ALU_READY,
  input  logic                       LSU_VALID,
  input  logic [4:0]                 LSU_RD,
  input  logic [31:0]                LSU_DATA,
  output logic                       LSU_READY,
  input  logic                       STALL,
  output logic [4:0]                 WA3,
  output logic [31:0]                WD3,
  output logic                       WE3,
  input  logic [4:0]                 QA1,
  input  logic [4:0]                 QA2,
  output logic                       PEND1,
  output logic                       PEND2,
  output logic [$clog2(DEPTH):0]     COUNT,
  output logic                       FULL,
  output logic                       EMPTY
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_ent_t;

  wb_ent_t         mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [AW-1:0]   head_q;
  logic [AW-1:0]   tail_q;
  logic [CW-1:0]   count_q;

  logic    push_alu;
  logic    push_lsu;
  logic    enq;
  logic    pop;
  wb_ent_t in_ent;

  assign FULL  = (count_q == CW'(DEPTH));
  assign EMPTY = (count_q == '0);
  assign COUNT = count_q;

  assign ALU_READY = !FULL;
  assign LSU_READY = !FULL && !ALU_VALID;

  assign push_alu = ALU_VALID && ALU_READY;
  assign push_lsu = LSU_VALID && LSU_READY;

  always_comb begin
    in_ent = '0;
    if (push_alu) begin
      in_ent.rd   = ALU_RD;
      in_ent.data = ALU_DATA;
    end else if (push_lsu) begin
      in_ent.rd   = LSU_RD;
      in_ent.data = LSU_DATA;
    end
  end

  // x0 writes complete the handshake but never occupy a slot
  assign enq = (push_alu || push_lsu) && (in_ent.rd != 5'd0);
  assign pop = !EMPTY && !STALL;

  assign WE3 = pop;
  assign WA3 = EMPTY ? 5'd0  : mem_q[head_q].rd;
  assign WD3 = EMPTY ? 32'd0 : mem_q[head_q].data;

  always_comb begin
    PEND1 = 1'b0;
    PEND2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && mem_q[i].rd == QA1 && QA1 != 5'd0)
        PEND1 = 1'b1;
      if (vld_q[i] && mem_q[i].rd == QA2 && QA2 != 5'd0)
        PEND2 = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      if (enq) begin
        mem_q[tail_q] <= in_ent;
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + AW'(1);
      end
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + AW'(1);
      end
      case ({enq, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: handshake, ordering, stall,
// x0 discard, hazard lookup and asynchronous reset behaviour.
module tb_writeback_queue;

  logic        CLK;
  logic        RST_N;
  logic        ALU_VALID;
  logic [4:0]  ALU_RD;
  logic [31:0] ALU_DATA;
  logic        ALU_READY;
  logic        LSU_VALID;
  logic [4:0]  LSU_RD;
  logic [31:0] LSU_DATA;
  logic        LSU_READY;
  logic        STALL;
  logic [4:0]  WA3;
  logic [31:0] WD3;
  logic        WE3;
  logic [4:0]  QA1;
  logic [4:0]  QA2;
  logic        PEND1;
  logic        PEND2;
  logic [2:0]  COUNT;
  logic        FULL;
  logic        EMPTY;

  int n_chk  = 0;
  int n_fail = 0;

  writeback_queue #(.DEPTH(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ALU_VALID(ALU_VALID), .ALU_RD(ALU_RD),
    .ALU_DATA(ALU_DATA), .ALU_READY(ALU_READY),
    .LSU_VALID(LSU_VALID), .LSU_RD(LSU_RD),
    .LSU_DATA(LSU_DATA), .LSU_READY(LSU_READY),
    .STALL(STALL),
    .WA3(WA3), .WD3(WD3), .WE3(WE3),
    .QA1(QA1), .QA2(QA2),
    .PEND1(PEND1), .PEND2(PEND2),
    .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic alu(input logic v, input logic [4:0] rd,
                     input logic [31:0] d);
    ALU_VALID = v;
    ALU_RD    = rd;
    ALU_DATA  = d;
  endtask

  initial begin
    RST_N = 1'b0;
    alu(1'b0, 5'd0, 32'd0);
    LSU_VALID = 1'b0;
    LSU_RD    = 5'd0;
    LSU_DATA  = 32'd0;
    STALL     = 1'b0;
    QA1       = 5'd0;
    QA2       = 5'd0;
    #3;
    chk("rst_we3", WE3, 0);
    chk("rst_empty", EMPTY, 1);
    chk("rst_full", FULL, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_alu_rdy", ALU_READY, 1);
    chk("rst_lsu_rdy", LSU_READY, 1);
    chk("rst_wa3", WA3, 0);
    chk("rst_wd3", WD3, 0);
    #9 RST_N = 1'b1;
    tick();

    // single push
    alu(1'b1, 5'd5, 32'hDEADBEEF);
    #1 chk("sp_alu_rdy", ALU_READY, 1);
    tick();
    alu(1'b0, 5'd0, 32'd0);
    #1;
    chk("sp_we3", WE3, 1);
    chk("sp_wa3", WA3, 5);
    chk("sp_wd3", WD3, 32'hDEADBEEF);
    chk("sp_count", COUNT, 1);
    tick();
    chk("sp_empty", EMPTY, 1);
    chk("sp_we3_off", WE3, 0);
    chk("sp_wd3_off", WD3, 0);

    // ALU vs LSU contention
    alu(1'b1, 5'd3, 32'h33);
    LSU_VALID = 1'b1;
    LSU_RD    = 5'd7;
    LSU_DATA  = 32'h77;
    #1;
    chk("ct_alu_rdy", ALU_READY, 1);
    chk("ct_lsu_rdy", LSU_READY, 0);
    tick();
    alu(1'b0, 5'd0, 32'd0);
    #1;
    chk("ct_lsu_rdy2", LSU_READY, 1);
    chk("ct_wa3_1", WA3, 3);
    chk("ct_wd3_1", WD3, 32'h33);
    tick();
    LSU_VALID = 1'b0;
    #1;
    chk("ct_wa3_2", WA3, 7);
    chk("ct_wd3_2", WD3, 32'h77);
    chk("ct_count", COUNT, 1);
    tick();
    chk("ct_empty", EMPTY, 1);

    // fill under stall, then drain; push while full with a pop
    STALL = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      alu(1'b1, 5'(i), 32'h100 + i);
      tick();
    end
    alu(1'b0, 5'd0, 32'd0);
    #1;
    chk("fl_full", FULL, 1);
    chk("fl_count", COUNT, 4);
    chk("fl_alu_rdy", ALU_READY, 0);
    chk("fl_we3", WE3, 0);
    STALL = 1'b0;
    alu(1'b1, 5'd10, 32'hAAAA);
    #1;
    chk("fl_rdy_pop", ALU_READY, 0);
    chk("fl_we3_on", WE3, 1);
    chk("dr_wa3_1", WA3, 1);
    chk("dr_wd3_1", WD3, 32'h101);
    tick();
    alu(1'b0, 5'd0, 32'd0);
    #1;
    chk("dr_count", COUNT, 3);
    for (int i = 2; i <= 4; i++) begin
      chk("dr_we3", WE3, 1);
      chk("dr_wa3", WA3, i);
      chk("dr_wd3", WD3, 32'h100 + i);
      tick();
    end
    chk("dr_empty", EMPTY, 1);
    chk("dr_we3_off", WE3, 0);

    // rd 0 handshake without enqueue
    alu(1'b1, 5'd0, 32'h12345678);
    #1 chk("x0_rdy", ALU_READY, 1);
    tick();
    alu(1'b0, 5'd0, 32'd0);
    #1;
    chk("x0_count", COUNT, 0);
    chk("x0_we3", WE3, 0);

    // hazard lookup ignores the same-cycle request
    STALL = 1'b1;
    QA1   = 5'd9;
    QA2   = 5'd0;
    alu(1'b1, 5'd9, 32'h99);
    #1 chk("hz_pend_in", PEND1, 0);
    tick();
    alu(1'b0, 5'd0, 32'd0);
    #1;
    chk("hz_pend1", PEND1, 1);
    chk("hz_pend2", PEND2, 0);
    QA2 = 5'd9;
    #1 chk("hz_pend2b", PEND2, 1);
    QA2 = 5'd5;
    #1 chk("hz_pend2c", PEND2, 0);
    STALL = 1'b0;
    tick();
    chk("hz_drain", PEND1, 0);
    chk("hz_empty", EMPTY, 1);

    // reset mid-operation
    STALL = 1'b1;
    for (int i = 4; i <= 6; i++) begin
      alu(1'b1, 5'(i), 32'h200 + i);
      tick();
    end
    alu(1'b0, 5'd0, 32'd0);
    #1 chk("mr_count3", COUNT, 3);
    STALL = 1'b0;
    RST_N = 1'b0;
    #1;
    chk("mr_we3", WE3, 0);
    chk("mr_count", COUNT, 0);
    chk("mr_empty", EMPTY, 1);
    chk("mr_wa3", WA3, 0);
    #2 RST_N = 1'b1;
    tick();
    chk("mr_post_we3", WE3, 0);
    chk("mr_post_empty", EMPTY, 1);

    // first edge after release accepts a push
    QA1 = 5'd0;
    QA2 = 5'd0;
    tick();
    RST_N = 1'b0;
    #2;
    RST_N = 1'b1;
    alu(1'b1, 5'd8, 32'h88);
    #1 chk("pr_rdy", ALU_READY, 1);
    tick();
    alu(1'b0, 5'd0, 32'd0);
    #1;
    chk("pr_we3", WE3, 1);
    chk("pr_wa3", WA3, 8);
    chk("pr_wd3", WD3, 32'h88);
    tick();
    chk("pr_empty", EMPTY, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
